// File: rtl/msp430_bb_arb_pkg.sv
// Shared definitions for the Blackbone external-memory arbiter.
//   arb_state_e   : access sequencer states (IDLE -> ISSUE -> RESP -> IDLE)
//   DEF_*         : default parameter values used by the top level
package msp430_bb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_PORTS  = 4;
  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/msp430_rr_arbiter.sv
// Combinational round-robin priority search.
//   req_i   : request vector, one bit per port
//   start_i : port index with highest priority; search wraps upward from here
//   gnt_o   : one-hot grant of the first requesting port found
//   idx_o   : index of that port
//   any_o   : at least one request present
module msp430_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int p;

  // Walk from the farthest offset toward start_i so the nearest requester
  // is the last one assigned and therefore wins, with no early exit needed.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    p     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      p = int'(start_i) + i;
      if (p >= N) p = p - N;
      if (req_i[p]) begin
        any_o = 1'b1;
        idx_o = IW'(p);
      end
    end
  end

  assign gnt_o = any_o ? (N'(1) << idx_o) : '0;

endmodule

// File: rtl/msp430_bb_ext_arbiter.sv
// Arbiter sharing the Blackbone external memory port among NUM_PORTS
// requesters. Each access takes three cycles: accept (IDLE), memory enable
// (ISSUE), completion (RESP). Round-robin between ports, with an optional
// lock that lets one port keep ownership for up to MAX_BURST accesses.
//   clk, rst           : clock, asynchronous active-low reset
//   req_valid/we/lock  : per-port request, write enable, keep-ownership flag
//   req_addr/req_din   : per-port address and write data, port p at slice p
//   req_ready          : one-hot accept strobe (IDLE only)
//   rsp_valid/rsp_dout : one-hot completion strobe and shared read data
//   bb_ext_*           : memory port; read data returns one cycle after en
//   grant_o            : index of current/last granted port
//   busy_o             : an access is in flight
module msp430_bb_ext_arbiter
  import msp430_bb_arb_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS-1:0]            req_we,
  input  logic [NUM_PORTS-1:0]            req_lock,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_din,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_dout,
  output logic [ADDR_WIDTH-1:0]           bb_ext_addr_o,
  output logic [DATA_WIDTH-1:0]           bb_ext_din_o,
  output logic                            bb_ext_en_o,
  output logic                            bb_ext_we_o,
  input  logic [DATA_WIDTH-1:0]           bb_ext_dout_i,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_o,
  output logic                            busy_o
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e          state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic                lock_q, lock_d;
  logic [BW-1:0]       burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                we_q, we_d;

  logic [ADDR_WIDTH-1:0] addr_a [NUM_PORTS];
  logic [DATA_WIDTH-1:0] din_a  [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_a[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign din_a[g]  = req_din[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search begins just past the last grant; reset value NUM_PORTS-1 makes
  // the first search after reset start at port 0.
  logic [GW-1:0]        start_ptr;
  logic [NUM_PORTS-1:0] rr_gnt;
  logic [GW-1:0]        rr_idx;
  logic                 rr_any;

  assign start_ptr = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + GW'(1);

  msp430_rr_arbiter #(
    .N  (NUM_PORTS),
    .IW (GW)
  ) u_rr (
    .req_i   (req_valid),
    .start_i (start_ptr),
    .gnt_o   (rr_gnt),
    .idx_o   (rr_idx),
    .any_o   (rr_any)
  );

  // lock_q is only left set while the owner still has burst budget, so a
  // held lock plus a live owner request means a locked re-grant. If the
  // owner is silent the plain round-robin result is used in the same cycle.
  logic          owner_hold;
  logic [GW-1:0] win_idx;
  logic          win_any;
  logic          accept;

  assign owner_hold = lock_q && req_valid[grant_q];
  assign win_idx    = owner_hold ? grant_q : rr_idx;
  assign win_any    = owner_hold || rr_any;
  assign accept     = rst && (state_q == IDLE) && win_any;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    lock_d  = lock_q;
    burst_d = burst_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          grant_d = win_idx;
          addr_d  = addr_a[win_idx];
          din_d   = din_a[win_idx];
          we_d    = req_we[win_idx];
          burst_d = owner_hold ? burst_q + BW'(1) : BW'(1);
          // Exhausted budget drops the lock; the owner then sits at the
          // bottom of the round-robin order because search starts past it.
          lock_d  = req_lock[win_idx] && (burst_d < BW'(MAX_BURST));
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= GW'(NUM_PORTS - 1);
      lock_q  <= 1'b0;
      burst_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      lock_q  <= lock_d;
      burst_q <= burst_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
    end
  end

  // All strobes decode from state_q, so an asynchronous reset kills an
  // in-flight enable or completion immediately.
  assign req_ready     = accept ? (NUM_PORTS'(1) << win_idx) : '0;
  assign bb_ext_en_o   = (state_q == ISSUE);
  assign bb_ext_we_o   = (state_q == ISSUE) && we_q;
  assign bb_ext_addr_o = addr_q;
  assign bb_ext_din_o  = din_q;
  assign rsp_valid     = (state_q == RESP) ? (NUM_PORTS'(1) << grant_q) : '0;
  assign rsp_dout      = ((state_q == RESP) && !we_q) ? bb_ext_dout_i : '0;
  assign grant_o       = grant_q;
  assign busy_o        = (state_q != IDLE);

  logic unused_ok;
  assign unused_ok = ^rr_gnt;

endmodule

// File: tb/tb_msp430_bb_ext_arbiter.sv
// Bench for msp430_bb_ext_arbiter: directed scenarios, a behavioural model
// compared every cycle, and literal expectations for the key scenarios.
module tb_msp430_bb_ext_arbiter;

  localparam int N  = 4;
  localparam int AW = 14;
  localparam int DW = 16;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_we, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_din;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_dout;
  logic [AW-1:0]   bb_ext_addr_o;
  logic [DW-1:0]   bb_ext_din_o;
  logic            bb_ext_en_o, bb_ext_we_o;
  logic [DW-1:0]   bb_ext_dout_i;
  logic [1:0]      grant_o;
  logic            busy_o;

  always #5 clk = ~clk;

  msp430_bb_ext_arbiter #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_din(req_din),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_dout(rsp_dout),
    .bb_ext_addr_o(bb_ext_addr_o), .bb_ext_din_o(bb_ext_din_o),
    .bb_ext_en_o(bb_ext_en_o), .bb_ext_we_o(bb_ext_we_o),
    .bb_ext_dout_i(bb_ext_dout_i), .grant_o(grant_o), .busy_o(busy_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous memory: read data appears the cycle after enable.
  logic [DW-1:0] mem [0:16383];
  logic [DW-1:0] mem_dout;
  assign bb_ext_dout_i = mem_dout;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'(i * 37 + 165);
    mem[16'h0010] = 16'hBEEF;
    mem_dout = '0;
  end

  always @(posedge clk) begin
    if (bb_ext_en_o) begin
      mem_dout <= mem[bb_ext_addr_o];
      if (bb_ext_we_o) mem[bb_ext_addr_o] <= bb_ext_din_o;
    end
  end

  // Behavioural model: phase counts cycles since accept (0 = idle).
  int            m_phase, m_last, m_cnt;
  bit            m_lock, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din, m_rexp;
  int            cyc = 0;

  function automatic int mwin();
    int p;
    if (m_phase != 0) return -1;
    if (m_lock && m_cnt < MB && req_valid[m_last]) return m_last;
    for (int k = 1; k <= N; k++) begin
      p = (m_last + k) % N;
      if (req_valid[p]) return p;
    end
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    int w;
    if (!rst) begin
      m_phase <= 0; m_last <= N - 1; m_cnt <= 0; m_lock <= 0;
      m_we <= 0; m_addr <= '0; m_din <= '0; m_rexp <= '0;
    end else begin
      case (m_phase)
        0: begin
          w = mwin();
          if (w >= 0) begin
            m_phase <= 1;
            m_cnt   <= (m_lock && m_cnt < MB && w == m_last) ? m_cnt + 1 : 1;
            m_last  <= w;
            m_lock  <= req_lock[w];
            m_we    <= req_we[w];
            m_addr  <= req_addr[w*AW +: AW];
            m_din   <= req_din[w*DW +: DW];
          end
        end
        1: begin m_phase <= 2; m_rexp <= mem[m_addr]; end
        default: m_phase <= 0;
      endcase
    end
  end

  int gq[$];
  int gc[$];
  int rsp2_cnt = 0;

  always @(negedge clk) begin
    int w;
    logic [N-1:0] e_ready, e_rsp;
    w = mwin();
    e_ready = (rst && w >= 0) ? N'(1) << w : '0;
    e_rsp   = (m_phase == 2) ? N'(1) << m_last : '0;
    chk("req_ready", req_ready, e_ready);
    chk("en", bb_ext_en_o, m_phase == 1);
    chk("we", bb_ext_we_o, m_phase == 1 && m_we);
    if (m_phase == 1 || !rst) begin
      chk("addr", bb_ext_addr_o, m_addr);
      chk("din", bb_ext_din_o, m_din);
    end
    chk("rsp_valid", rsp_valid, e_rsp);
    chk("rsp_dout", rsp_dout, (m_phase == 2 && !m_we) ? m_rexp : '0);
    chk("grant", grant_o, m_last);
    chk("busy", busy_o, m_phase != 0);
    if (rsp_valid[2]) rsp2_cnt++;
    for (int i = 0; i < N; i++)
      if (req_ready[i]) begin gq.push_back(i); gc.push_back(cyc); end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int b = 0;
    while (gq.size() < n && b < budget) begin @(negedge clk); b++; end
    chk("grant_count", gq.size() >= n, 1);
  endtask

  initial begin
    int r0;
    int exp37 [5] = '{0, 1, 2, 3, 0};
    int exp38 [7] = '{1, 1, 1, 1, 2, 3, 0};
    rst = 1'b0; req_valid = '0; req_we = '0; req_lock = '0;
    req_addr = '0; req_din = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_grant", grant_o, 3);
    chk("rst_busy", busy_o, 0);
    chk("rst_en", bb_ext_en_o, 0);
    step(); rst = 1'b1;
    step();

    // single read, port 2
    req_valid = 4'b0100; req_addr[2*AW +: AW] = 14'h0010; req_we = '0;
    @(negedge clk); chk("rd_ready", req_ready, 4'b0100);
    step(); req_valid = '0;
    @(negedge clk); chk("rd_en", bb_ext_en_o, 1); chk("rd_addr", bb_ext_addr_o, 14'h0010);
    step();
    @(negedge clk); chk("rd_rsp", rsp_valid, 4'b0100); chk("rd_dout", rsp_dout, 16'hBEEF);
    step();

    // single write, port 3
    req_valid = 4'b1000; req_we = 4'b1000;
    req_addr[3*AW +: AW] = 14'h3FFF; req_din[3*DW +: DW] = 16'h1234;
    @(negedge clk); chk("wr_ready", req_ready, 4'b1000);
    step(); req_valid = '0; req_we = '0;
    @(negedge clk); chk("wr_we", bb_ext_we_o, 1); chk("wr_din", bb_ext_din_o, 16'h1234);
    step();
    @(negedge clk); chk("wr_rsp", rsp_valid, 4'b1000); chk("wr_dout", rsp_dout, 0);
    chk("wr_we_off", bb_ext_we_o, 0);
    step();
    @(negedge clk); chk("wr_mem", mem[14'h3FFF], 16'h1234);

    // all ports, no lock
    for (int p = 0; p < N; p++) req_addr[p*AW +: AW] = 14'(16'h100 + p);
    gq.delete(); gc.delete();
    step(); req_valid = 4'hF;
    wait_grants(5, 60);
    step(); req_valid = '0;
    for (int i = 0; i < 5; i++)
      if (i < gq.size()) chk($sformatf("rr_order%0d", i), gq[i], exp37[i]);
    for (int i = 1; i < 5; i++)
      if (i < gc.size()) chk($sformatf("rr_gap%0d", i), gc[i] - gc[i-1], 3);
    repeat (3) step();

    // port 1 locked burst
    gq.delete(); gc.delete();
    req_valid = 4'hF; req_lock = 4'b0010;
    wait_grants(7, 100);
    step(); req_valid = '0; req_lock = '0;
    for (int i = 0; i < 7; i++)
      if (i < gq.size()) chk($sformatf("lock_order%0d", i), gq[i], exp38[i]);
    repeat (3) step();

    // reset during ISSUE
    req_valid = 4'b0100;
    @(negedge clk); chk("rs_ready", req_ready, 4'b0100);
    step(); req_valid = 4'b0101;
    @(negedge clk); chk("rs_en", bb_ext_en_o, 1);
    r0 = rsp2_cnt;
    #2 rst = 1'b0;
    #1 chk("rs_en_drop", bb_ext_en_o, 0); chk("rs_busy", busy_o, 0);
    chk("rs_rsp", rsp_valid, 0); chk("rs_ready0", req_ready, 0);
    step(); step(); rst = 1'b1;
    @(negedge clk); chk("rs_first", req_ready, 4'b0001);
    step(); req_valid = '0;
    repeat (4) step();
    chk("rs_no_rsp2", rsp2_cnt - r0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
